// File: rtl/aimc_lib.sv
// Shared interconnect types: packet, read type, channel count, and the FIFO
// entry carried through the ordering-buffer transmitter.
package aimc_lib;

  localparam int CH_NUM = 4;
  localparam int CH_W   = $clog2(CH_NUM);

  typedef enum logic [1:0] {
    RD_NORMAL   = 2'd0,
    RD_PREFETCH = 2'd1,
    RD_STREAM   = 2'd2,
    RD_ATOMIC   = 2'd3
  } rd_t;

  typedef struct packed {
    logic [11:0] row_addr;
    logic [5:0]  col_addr;
  } pkt_t;

  typedef struct packed {
    rd_t  rd_type;
    pkt_t pkt;
  } icnt_tx_entry_t;

  // First requesting channel strictly after 'last', wrapping; 'last' itself is
  // the final candidate so a lone requester is always found.
  function automatic logic [CH_W-1:0] rr_pick(input logic [CH_NUM-1:0] req,
                                              input logic [CH_W-1:0]   last);
    logic [CH_W-1:0] pick;
    logic [CH_W-1:0] idx;
    pick = last;
    for (int k = CH_NUM; k >= 1; k--) begin
      idx = CH_W'((int'(last) + k) % CH_NUM);
      if (req[idx]) pick = idx;
    end
    return pick;
  endfunction

endpackage

// File: rtl/icnt_tx_ch_fifo.sv
// Per-channel synchronous FIFO of {rd_type, pkt} entries; no bypass, so a full
// FIFO refuses a push even in a cycle where it pops.
module icnt_tx_ch_fifo
  import aimc_lib::*;
#(
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           push,
  input  logic           pop,
  input  icnt_tx_entry_t din,
  output icnt_tx_entry_t dout,
  output logic           empty,
  output logic           full
);

  localparam int PTR_W = $clog2(DEPTH);

  icnt_tx_entry_t   mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // NOTE: storage has no reset; count decides what is valid, so stale words are never observed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == (PTR_W + 1)'(DEPTH));

endmodule

// File: rtl/icnt_orde_tx.sv
// Ordering-buffer transmitter: per-channel FIFOs, round-robin arbiter and one
// output register. Define ICNT_TX_BURST_LOCK_EN to let a channel hold the grant.
module icnt_orde_tx
  import aimc_lib::*;
#(
  parameter int CH_FIFO_DEPTH = 4,
  parameter int BURST_LEN     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CH_NUM-1:0] ch_pkt_valid,
  input  pkt_t              ch_pkt [CH_NUM],
  input  rd_t               ch_pkt_rd_type [CH_NUM],
  output logic [CH_NUM-1:0] ch_pkt_rdy,
  output logic              icnt_orde_pkt_valid,
  output pkt_t              icnt_orde_pkt,
  output rd_t               icnt_orde_pkt_rd_type,
  output logic [CH_W-1:0]   icnt_orde_pkt_ch_addr,
  input  logic              orde_rdy,
  output logic              tx_busy
);

  icnt_tx_entry_t    head [CH_NUM];
  logic [CH_NUM-1:0] empty;
  logic [CH_NUM-1:0] full;
  logic [CH_NUM-1:0] req;
  logic [CH_NUM-1:0] pop;
  logic [CH_W-1:0]   last_grant;
  logic [CH_W-1:0]   grant_idx;
  logic              load;

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    icnt_tx_ch_fifo #(.DEPTH(CH_FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (ch_pkt_valid[i] && ch_pkt_rdy[i]),
      .pop   (pop[i]),
      .din   ({ch_pkt_rd_type[i], ch_pkt[i]}),
      .dout  (head[i]),
      .empty (empty[i]),
      .full  (full[i])
    );
    // Held low during reset so upstream never sees a handshake it would lose.
    assign ch_pkt_rdy[i] = rst_n && !full[i];
  end

  assign req  = ~empty;
  assign load = (!icnt_orde_pkt_valid || orde_rdy) && (|req);

`ifdef ICNT_TX_BURST_LOCK_EN
  localparam int BC_W = $clog2(BURST_LEN) + 1;

  logic [BC_W-1:0] burst_cnt;
  logic            hold;

  assign hold      = req[last_grant] && (burst_cnt < BC_W'(BURST_LEN - 1));
  assign grant_idx = hold ? last_grant : rr_pick(req, last_grant);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    burst_cnt <= '0;
    else if (load) burst_cnt <= hold ? burst_cnt + 1'b1 : '0;
  end
`else
  // Burst length only matters when the grant can be held.
  localparam int unused_burst_len = BURST_LEN;

  assign grant_idx = rr_pick(req, last_grant);
`endif

  // NOTE: default assigned first so no path through this block leaves pop unassigned (no latch).
  always_comb begin
    pop = '0;
    if (load) pop[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      icnt_orde_pkt_valid   <= 1'b0;
      icnt_orde_pkt         <= '0;
      icnt_orde_pkt_rd_type <= RD_NORMAL;
      icnt_orde_pkt_ch_addr <= '0;
      last_grant            <= CH_W'(CH_NUM - 1);
    end else if (load) begin
      icnt_orde_pkt_valid   <= 1'b1;
      icnt_orde_pkt         <= head[grant_idx].pkt;
      icnt_orde_pkt_rd_type <= head[grant_idx].rd_type;
      icnt_orde_pkt_ch_addr <= grant_idx;
      last_grant            <= grant_idx;
    end else if (orde_rdy) begin
      icnt_orde_pkt_valid   <= 1'b0;
    end
  end

  assign tx_busy = (|req) || icnt_orde_pkt_valid;

endmodule

// File: tb/tb_icnt_orde_tx.sv
// Directed bench for icnt_orde_tx: per-channel source queues drive the inputs,
// and a scoreboard of expected {ch_addr, entry} is compared on every transfer.
`timescale 1ns/1ps
module tb_icnt_orde_tx;
  import aimc_lib::*;

  typedef struct packed {
    logic [CH_W-1:0] ch;
    icnt_tx_entry_t  e;
  } obs_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [CH_NUM-1:0] ch_pkt_valid;
  pkt_t              ch_pkt [CH_NUM];
  rd_t               ch_pkt_rd_type [CH_NUM];
  logic [CH_NUM-1:0] ch_pkt_rdy;
  logic              icnt_orde_pkt_valid;
  pkt_t              icnt_orde_pkt;
  rd_t               icnt_orde_pkt_rd_type;
  logic [CH_W-1:0]   icnt_orde_pkt_ch_addr;
  logic              orde_rdy;
  logic              tx_busy;

  int checks = 0;
  int errors = 0;

  icnt_tx_entry_t src_q [CH_NUM][$];
  obs_t           exp_q [$];

  icnt_orde_tx #(.CH_FIFO_DEPTH(4), .BURST_LEN(4)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .ch_pkt_valid          (ch_pkt_valid),
    .ch_pkt                (ch_pkt),
    .ch_pkt_rd_type        (ch_pkt_rd_type),
    .ch_pkt_rdy            (ch_pkt_rdy),
    .icnt_orde_pkt_valid   (icnt_orde_pkt_valid),
    .icnt_orde_pkt         (icnt_orde_pkt),
    .icnt_orde_pkt_rd_type (icnt_orde_pkt_rd_type),
    .icnt_orde_pkt_ch_addr (icnt_orde_pkt_ch_addr),
    .orde_rdy              (orde_rdy),
    .tx_busy               (tx_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic icnt_tx_entry_t mk(input int row, input int col, input int rd);
    icnt_tx_entry_t e;
    e.rd_type      = rd_t'(rd % 4);
    e.pkt.row_addr = 12'(row);
    e.pkt.col_addr = 6'(col);
    return e;
  endfunction

  task automatic send(input int ch, input icnt_tx_entry_t e);
    src_q[ch].push_back(e);
  endtask

  task automatic expect_out(input int ch, input icnt_tx_entry_t e);
    obs_t o;
    o.ch = CH_W'(ch);
    o.e  = e;
    exp_q.push_back(o);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    for (int i = 0; i < CH_NUM; i++) src_q[i].delete();
    exp_q.delete();
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || icnt_orde_pkt_valid) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(exp_q.size()), 64'd0);
    check({tag, "_busy"}, 64'(tx_busy), 64'd0);
  endtask

  // Source driver: holds each channel's head packet until it is accepted.
  initial begin
    logic [CH_NUM-1:0] fire;
    ch_pkt_valid = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      ch_pkt[i]         = '0;
      ch_pkt_rd_type[i] = RD_NORMAL;
    end
    forever begin
      @(negedge clk); #1;
      fire = ch_pkt_valid & ch_pkt_rdy;
      @(posedge clk); #1;
      for (int i = 0; i < CH_NUM; i++) begin
        if (fire[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        if (src_q[i].size() > 0) begin
          ch_pkt_valid[i]   = 1'b1;
          ch_pkt[i]         = src_q[i][0].pkt;
          ch_pkt_rd_type[i] = src_q[i][0].rd_type;
        end else begin
          ch_pkt_valid[i]   = 1'b0;
        end
      end
    end
  end

  // Output monitor: every completed transfer must match the scoreboard head.
  initial begin
    obs_t got;
    obs_t want;
    forever begin
      @(negedge clk); #1;
      if (rst_n && icnt_orde_pkt_valid && orde_rdy) begin
        got.ch        = icnt_orde_pkt_ch_addr;
        got.e.rd_type = icnt_orde_pkt_rd_type;
        got.e.pkt     = icnt_orde_pkt;
        check("sb_pending", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          want = exp_q.pop_front();
          check("sb_output", 64'(got), 64'(want));
        end
      end
    end
  end

  initial begin
    pkt_t            snap_pkt;
    logic [CH_W-1:0] snap_ch;
    int              n;

    rst_n    = 1'b0;
    orde_rdy = 1'b1;
    #2;
    check("rst_rdy_low",  64'(ch_pkt_rdy), 64'h0);
    check("rst_valid",    64'(icnt_orde_pkt_valid), 64'd0);
    check("rst_pkt",      64'(icnt_orde_pkt), 64'd0);
    check("rst_rd_type",  64'(icnt_orde_pkt_rd_type), 64'd0);
    check("rst_ch_addr",  64'(icnt_orde_pkt_ch_addr), 64'd0);
    check("rst_busy",     64'(tx_busy), 64'd0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    check("rdy_after_rst", 64'(ch_pkt_rdy), 64'hF);

    // Single packet: accepted in cycle 0, visible in cycle 2 for one cycle.
    send(0, mk('h12, 3, 1));
    expect_out(0, mk('h12, 3, 1));
    tick(2);
    check("single_not_yet", 64'(icnt_orde_pkt_valid), 64'd0);
    tick(1);
    check("single_valid",   64'(icnt_orde_pkt_valid), 64'd1);
    check("single_ch",      64'(icnt_orde_pkt_ch_addr), 64'd0);
    check("single_row",     64'(icnt_orde_pkt.row_addr), 64'h12);
    check("single_col",     64'(icnt_orde_pkt.col_addr), 64'h3);
    tick(1);
    check("single_one_cyc", 64'(icnt_orde_pkt_valid), 64'd0);
    check("single_idle",    64'(tx_busy), 64'd0);

    // Simultaneous push on all channels: back-to-back 0,1,2,3.
    apply_reset();
    for (int c = 0; c < CH_NUM; c++) begin
      send(c, mk('h40 + c, c, c));
      expect_out(c, mk('h40 + c, c, c));
    end
    tick(3);
    for (int c = 0; c < CH_NUM; c++) begin
      check("simul_valid", 64'(icnt_orde_pkt_valid), 64'd1);
      check("simul_ch",    64'(icnt_orde_pkt_ch_addr), 64'(c));
      tick(1);
    end
    wait_drain("simul_drain", 20);

    // Backpressure: 4 in FIFO plus 1 in the output stage, then ready falls.
    orde_rdy = 1'b0;
    for (int k = 0; k < 8; k++) begin
      send(2, mk('h300 + k, k, k));
      expect_out(2, mk('h300 + k, k, k));
    end
    n = 0;
    while (ch_pkt_rdy[2] && n < 30) begin
      tick(1);
      n++;
    end
    check("bp_rdy_fell",   64'(ch_pkt_rdy[2]), 64'd0);
    check("bp_accepted",   64'(8 - src_q[2].size()), 64'd5);
    check("bp_valid",      64'(icnt_orde_pkt_valid), 64'd1);
    snap_pkt = icnt_orde_pkt;
    snap_ch  = icnt_orde_pkt_ch_addr;
    check("bp_first_col",  64'(snap_pkt.col_addr), 64'd0);
    tick(4);
    check("bp_hold_pkt",   64'(icnt_orde_pkt), 64'(snap_pkt));
    check("bp_hold_ch",    64'(icnt_orde_pkt_ch_addr), 64'(snap_ch));
    check("bp_hold_valid", 64'(icnt_orde_pkt_valid), 64'd1);
    check("bp_still_full", 64'(ch_pkt_rdy[2]), 64'd0);
    orde_rdy = 1'b1;
    wait_drain("bp_drain", 40);

    // Burst lock: ch0 has 6 packets, ch1 has 2, all queued behind a stall.
    apply_reset();
    orde_rdy = 1'b0;
    for (int k = 0; k < 6; k++) send(0, mk('h100 + k, k, 0));
    for (int k = 0; k < 2; k++) send(1, mk('h200 + k, k, 1));
`ifdef ICNT_TX_BURST_LOCK_EN
    for (int k = 0; k < 4; k++) expect_out(0, mk('h100 + k, k, 0));
    for (int k = 0; k < 2; k++) expect_out(1, mk('h200 + k, k, 1));
    for (int k = 4; k < 6; k++) expect_out(0, mk('h100 + k, k, 0));
`else
    expect_out(0, mk('h100, 0, 0));
    expect_out(1, mk('h200, 0, 1));
    expect_out(0, mk('h101, 1, 0));
    expect_out(1, mk('h201, 1, 1));
    for (int k = 2; k < 6; k++) expect_out(0, mk('h100 + k, k, 0));
`endif
    tick(10);
    check("burst_stage_ch", 64'(icnt_orde_pkt_ch_addr), 64'd0);
    orde_rdy = 1'b1;
    wait_drain("burst_drain", 40);

    // Reset mid-operation: valid drops without a clock edge, buffers discarded.
    orde_rdy = 1'b0;
    for (int k = 0; k < 3; k++) send(0, mk('h7a0 + k, k, 2));
    tick(6);
    check("midrst_pre_valid", 64'(icnt_orde_pkt_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 64'(icnt_orde_pkt_valid), 64'd0);
    check("midrst_busy",  64'(tx_busy), 64'd0);
    check("midrst_rdy",   64'(ch_pkt_rdy), 64'h0);
    for (int i = 0; i < CH_NUM; i++) src_q[i].delete();
    exp_q.delete();
    tick(2);
    rst_n = 1'b1;
    tick(1);
    check("postrst_busy", 64'(tx_busy), 64'd0);
    send(3, mk('h333, 7, 3));
    expect_out(3, mk('h333, 7, 3));
    orde_rdy = 1'b1;
    wait_drain("postrst_drain", 20);

    // Pointer wrap: 20 packets on ch1 under random backpressure.
    for (int k = 0; k < 20; k++) begin
      send(1, mk('h500, k, k));
      expect_out(1, mk('h500, k, k));
    end
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      orde_rdy = 1'($urandom_range(0, 1));
      n++;
    end
    orde_rdy = 1'b1;
    wait_drain("wrap_drain", 20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
